pc_ras: RTL and testbench

//  Next-generation program counter: generates instruction-memory addresses with increment,

---
 rtl/pc_pkg.sv | 23 ++
 rtl/ras_stack.sv | 56 +++++
 rtl/pc_ras.sv | 118 +++++++++++
 tb/tb_pc_ras.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program counter with return-address stack.
// Op encodings come from the control unit; states report the last PC action.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_BRZ  = 3'd0,
    OP_BRNZ = 3'd1,
    OP_JUMP = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_t;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INCR   = 3'd1,
    S_BRANCH = 3'd2,
    S_JUMP   = 3'd3,
    S_CALL   = 3'd4,
    S_RET    = 3'd5,
    S_STALL  = 3'd6
  } pc_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: register array plus fill count.
// Only the count is reset; entry contents are don't-care until pushed.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  assign wr_idx = IW'(cnt_q);
  assign rd_idx = IW'(cnt_q - CW'(1));
  assign top    = mem_q[rd_idx];

  // Push and pop never coincide; a push into a full stack is dropped.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      cnt_d         = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pc_ras.sv
// Program counter with relative branch, jump, call/return via a RAS,
// pipeline stall and sticky stack overflow/underflow flags.
module pc_ras
  import pc_pkg::*;
#(
  parameter int                   BUS_WIDTH  = 16,
  parameter int                   OFS_WIDTH  = 6,
  parameter int                   RAS_DEPTH  = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           PL,
  input  logic [2:0]                     op,
  input  logic                           stall,
  input  logic [OFS_WIDTH-1:0]           offset,
  input  logic                           zero,
  input  logic [BUS_WIDTH-1:0]           address_bus_A,
  input  logic                           flag_clr,
  output logic [BUS_WIDTH-1:0]           instr_addr,
  output pc_state_t                      state,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  pc_state_t            st_q, st_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [BUS_WIDTH-1:0] pc_inc;
  logic [BUS_WIDTH-1:0] pc_br;
  logic [BUS_WIDTH-1:0] ras_top;
  logic                 push;
  logic                 pop;

  assign pc_inc = pc_q + BUS_WIDTH'(1);
  assign pc_br  = pc_q + {{(BUS_WIDTH-OFS_WIDTH){offset[OFS_WIDTH-1]}}, offset};

  ras_stack #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_comb begin
    pc_d  = pc_inc;
    st_d  = S_INCR;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = ovf_q & ~flag_clr;
    unf_d = unf_q & ~flag_clr;
    if (stall) begin
      pc_d = pc_q;
      st_d = S_STALL;
    end else if (PL) begin
      case (op)
        OP_BRZ: if (zero) begin
          pc_d = pc_br;
          st_d = S_BRANCH;
        end
        OP_BRNZ: if (!zero) begin
          pc_d = pc_br;
          st_d = S_BRANCH;
        end
        OP_JUMP: begin
          pc_d = address_bus_A;
          st_d = S_JUMP;
        end
        OP_CALL: begin
          pc_d = address_bus_A;
          st_d = S_CALL;
          push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
        end
        OP_RET: if (ras_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d = ras_top;
          st_d = S_RET;
          pop  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_ADDR;
      st_q  <= S_RESET;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      st_q  <= st_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign instr_addr = pc_q;
  assign state      = st_q;
  assign ras_ovf    = ovf_q;
  assign ras_unf    = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras: sequencing, branches, call/return,
// stack overflow/underflow, stall, wraparound and async reset.
module tb_pc_ras;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        PL;
  logic [2:0]  op;
  logic        stall;
  logic [5:0]  offset;
  logic        zero;
  logic [15:0] address_bus_A;
  logic        flag_clr;
  logic [15:0] instr_addr;
  pc_state_t   state;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int nvec = 0;
  int nerr = 0;

  pc_ras #(
    .BUS_WIDTH  (16),
    .OFS_WIDTH  (6),
    .RAS_DEPTH  (4),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PL            (PL),
    .op            (op),
    .stall         (stall),
    .offset        (offset),
    .zero          (zero),
    .address_bus_A (address_bus_A),
    .flag_clr      (flag_clr),
    .instr_addr    (instr_addr),
    .state         (state),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_ovf       (ras_ovf),
    .ras_unf       (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic pl, input logic [2:0] o,
                     input logic [15:0] a);
    PL = pl;
    op = o;
    address_bus_A = a;
  endtask

  initial begin
    reset = 1'b0;
    PL = 1'b0;
    op = 3'd0;
    stall = 1'b0;
    offset = '0;
    zero = 1'b0;
    address_bus_A = '0;
    flag_clr = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("rst_pc", instr_addr, 32'h0000);
    chk("rst_st", state, S_RESET);
    chk("rst_cnt", ras_count, 0);
    chk("rst_emp", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_ovf", ras_ovf, 0);
    chk("rst_unf", ras_unf, 0);

    reset = 1'b1;
    step();
    chk("inc1", instr_addr, 32'h0001);
    chk("inc1_st", state, S_INCR);
    step();
    chk("inc2", instr_addr, 32'h0002);
    step();
    chk("inc3", instr_addr, 32'h0003);

    drv(1, OP_JUMP, 16'h0010);
    step();
    chk("jmp", instr_addr, 32'h0010);
    chk("jmp_st", state, S_JUMP);
    drv(1, OP_BRZ, 16'h0);
    offset = 6'b111100;
    zero = 1'b1;
    step();
    chk("brz_t", instr_addr, 32'h000C);
    chk("brz_t_st", state, S_BRANCH);
    drv(1, OP_JUMP, 16'h0010);
    step();
    drv(1, OP_BRZ, 16'h0);
    zero = 1'b0;
    step();
    chk("brz_n", instr_addr, 32'h0011);
    chk("brz_n_st", state, S_INCR);
    drv(1, OP_BRNZ, 16'h0);
    offset = 6'd2;
    step();
    chk("brnz_t", instr_addr, 32'h0013);
    chk("brnz_t_st", state, S_BRANCH);
    zero = 1'b1;
    step();
    chk("brnz_n", instr_addr, 32'h0014);
    drv(1, 3'd6, 16'h0);
    step();
    chk("bad_op", instr_addr, 32'h0015);
    chk("bad_op_st", state, S_INCR);

    drv(1, OP_JUMP, 16'h0005);
    step();
    drv(1, OP_CALL, 16'hF0F0);
    step();
    chk("call", instr_addr, 32'hF0F0);
    chk("call_st", state, S_CALL);
    chk("call_cnt", ras_count, 1);
    drv(1, OP_RET, 16'h0);
    step();
    chk("ret", instr_addr, 32'h0006);
    chk("ret_st", state, S_RET);
    chk("ret_cnt", ras_count, 0);
    chk("ret_emp", ras_empty, 1);

    drv(1, OP_CALL, 16'h1000);
    for (int i = 0; i < 4; i++) step();
    chk("c4_cnt", ras_count, 4);
    chk("c4_full", ras_full, 1);
    chk("c4_ovf", ras_ovf, 0);
    step();
    chk("c5_pc", instr_addr, 32'h1000);
    chk("c5_cnt", ras_count, 4);
    chk("c5_ovf", ras_ovf, 1);
    drv(0, OP_BRZ, 16'h0);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    chk("clr_ovf", ras_ovf, 0);
    chk("clr_pc", instr_addr, 32'h1001);
    drv(1, OP_RET, 16'h0);
    for (int i = 0; i < 3; i++) step();
    chk("pop3_pc", instr_addr, 32'h1001);
    chk("pop3_cnt", ras_count, 1);
    step();
    chk("pop4_pc", instr_addr, 32'h0007);
    chk("pop4_emp", ras_empty, 1);

    drv(1, OP_JUMP, 16'h0020);
    step();
    drv(1, OP_RET, 16'h0);
    step();
    chk("unf_pc", instr_addr, 32'h0021);
    chk("unf_st", state, S_INCR);
    chk("unf", ras_unf, 1);
    drv(0, OP_BRZ, 16'h0);
    stall = 1'b1;
    step();
    chk("stl1_pc", instr_addr, 32'h0021);
    chk("stl1_st", state, S_STALL);
    drv(1, OP_JUMP, 16'h5555);
    step();
    chk("stl2_pc", instr_addr, 32'h0021);
    chk("stl2_unf", ras_unf, 1);
    stall = 1'b0;
    drv(1, OP_RET, 16'h0);
    flag_clr = 1'b1;
    step();
    chk("setwin_unf", ras_unf, 1);
    chk("setwin_pc", instr_addr, 32'h0022);
    drv(0, OP_BRZ, 16'h0);
    step();
    flag_clr = 1'b0;
    chk("clr_unf", ras_unf, 0);
    chk("clr_unf_pc", instr_addr, 32'h0023);

    drv(1, OP_JUMP, 16'hFFFF);
    step();
    drv(0, OP_BRZ, 16'h0);
    step();
    chk("wrap_inc", instr_addr, 32'h0000);
    step();
    drv(1, OP_BRNZ, 16'h0);
    zero = 1'b0;
    offset = 6'b111110;
    step();
    chk("wrap_br", instr_addr, 32'hFFFF);
    drv(1, OP_CALL, 16'hABCD);
    step();
    chk("pre_rst_cnt", ras_count, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_pc", instr_addr, 32'h0000);
    chk("arst_cnt", ras_count, 0);
    chk("arst_st", state, S_RESET);
    chk("arst_emp", ras_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
